// File: rtl/blk_mem_serializer_pkg.sv
// rtl/blk_mem_serializer_pkg.sv - shared types for the block memory serializer
package blk_mem_serializer_pkg;

    // IDLE: accepting requests; SEND: streaming flits of the latched block.
    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/blk_mem_serializer_counter.sv
// rtl/blk_mem_serializer_counter.sv - clear-up counter, counts 0..max_val_p
// Ports: clk_i, reset_n_i (async active-low), clear_i (priority over up_i),
//        up_i (increment), count_o (current value).
module blk_mem_serializer_counter #(
    parameter int max_val_p   = 3,
    parameter int width_lp    = (max_val_p < 2) ? 1 : $clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                clear_i,
    input  logic                up_i,
    output logic [width_lp-1:0] count_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (up_i) begin
            count_o <= count_o + width_lp'(1);
        end
    end

endmodule

// File: rtl/blk_mem_serializer_mem.sv
// rtl/blk_mem_serializer_mem.sv - byte-masked 1rw block memory, registered read
// Ports: clk_i, reset_n_i (clears only the read register), v_i, w_i, addr_i,
//        data_i, w_mask_i (one bit per byte), rdata_o (read register, X/Z as 0).
module blk_mem_serializer_mem #(
    parameter int block_width_p = 128,
    parameter int mem_els_p     = 16,
    parameter int addr_width_lp = (mem_els_p < 2) ? 1 : $clog2(mem_els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic                       w_i,
    input  logic [addr_width_lp-1:0]   addr_i,
    input  logic [block_width_p-1:0]   data_i,
    input  logic [block_width_p/8-1:0] w_mask_i,
    output logic [block_width_p-1:0]   rdata_o
);

    logic [block_width_p-1:0] mem [mem_els_p];
    logic [block_width_p-1:0] rdata_r;

    // Contents survive reset; only the output register is cleared.
    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int b = 0; b < block_width_p/8; b++) begin
                if (w_mask_i[b]) begin
                    mem[addr_i][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdata_r <= '0;
        end else if (v_i && !w_i) begin
            rdata_r <= mem[addr_i];
        end
    end

    // Never-written locations read back as 0 rather than propagating X.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < block_width_p; i++) begin
            rdata_o[i] = (rdata_r[i] === 1'b1);
        end
    end

    addr_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        v_i |-> (int'(addr_i) < mem_els_p))
        else $fatal(1, "blk_mem_serializer_mem: address out of range");

endmodule

// File: rtl/blk_mem_serializer_piso.sv
// rtl/blk_mem_serializer_piso.sv - passthrough parallel-in serial-out slice
// Ports: clk_i, reset_n_i, send_i (block held in rdata_i is being streamed),
//        rdata_i, ready_and_i, v_o, data_o, last_o, count_o (flit index).
module blk_mem_serializer_piso #(
    parameter int width_p        = 32,
    parameter int els_p          = 4,
    parameter int count_width_lp = $clog2(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      send_i,
    input  logic [width_p*els_p-1:0]  rdata_i,
    input  logic                      ready_and_i,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    output logic                      last_o,
    output logic [count_width_lp-1:0] count_o
);

    logic handshake;

    assign v_o       = send_i;
    assign last_o    = send_i && (count_o == count_width_lp'(els_p - 1));
    assign data_o    = send_i ? rdata_i[int'(count_o)*width_p +: width_p] : '0;
    assign handshake = v_o && ready_and_i;

    blk_mem_serializer_counter #(
        .max_val_p (els_p - 1),
        .width_lp  (count_width_lp)
    ) counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (handshake && last_o),
        .up_i      (handshake && !last_o),
        .count_o   (count_o)
    );

endmodule

// File: rtl/blk_mem_serializer.sv
// rtl/blk_mem_serializer.sv - block memory whose read blocks stream out as flits
// Ports: clk_i, reset_n_i (async active-low); request side v_i, w_i, addr_i,
//        data_i, w_mask_i, ready_and_o; flit side v_o, data_o, last_o,
//        count_o, ready_and_i.
module blk_mem_serializer
    import blk_mem_serializer_pkg::*;
#(
    parameter int width_p        = 32,
    parameter int els_p          = 4,
    parameter int mem_els_p      = 16,
    parameter int block_width_lp = width_p * els_p,
    parameter int addr_width_lp  = (mem_els_p < 2) ? 1 : $clog2(mem_els_p),
    parameter int count_width_lp = $clog2(els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        v_i,
    input  logic                        w_i,
    input  logic [addr_width_lp-1:0]    addr_i,
    input  logic [block_width_lp-1:0]   data_i,
    input  logic [block_width_lp/8-1:0] w_mask_i,
    output logic                        ready_and_o,
    output logic                        v_o,
    output logic [width_p-1:0]          data_o,
    output logic                        last_o,
    output logic [count_width_lp-1:0]   count_o,
    input  logic                        ready_and_i
);

    state_e                    state;
    logic [block_width_lp-1:0] rdata;
    logic                      accept;
    logic                      read_accept;
    logic                      final_handshake;

    // Ready combinationally follows ready_and_i on the last flit so a new
    // read can chain onto the outgoing block without a bubble.
    assign final_handshake = v_o && ready_and_i && last_o;
    assign ready_and_o     = (state == STATE_IDLE) || final_handshake;
    assign accept          = v_i && ready_and_o;
    assign read_accept     = accept && !w_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= STATE_IDLE;
        end else begin
            case (state)
                STATE_IDLE: if (read_accept) state <= STATE_SEND;
                STATE_SEND: if (final_handshake && !read_accept) state <= STATE_IDLE;
                default:    state <= STATE_IDLE;
            endcase
        end
    end

    // Memory is only touched when a request is accepted, so the read
    // register is stable for the whole serialization.
    blk_mem_serializer_mem #(
        .block_width_p (block_width_lp),
        .mem_els_p     (mem_els_p),
        .addr_width_lp (addr_width_lp)
    ) mem (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (accept),
        .w_i       (w_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .w_mask_i  (w_mask_i),
        .rdata_o   (rdata)
    );

    blk_mem_serializer_piso #(
        .width_p        (width_p),
        .els_p          (els_p),
        .count_width_lp (count_width_lp)
    ) piso (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .send_i      (state == STATE_SEND),
        .rdata_i     (rdata),
        .ready_and_i (ready_and_i),
        .v_o         (v_o),
        .data_o      (data_o),
        .last_o      (last_o),
        .count_o     (count_o)
    );

endmodule

// File: tb/tb_blk_mem_serializer.sv
// tb/tb_blk_mem_serializer.sv - self-checking scoreboard bench for blk_mem_serializer
module tb_blk_mem_serializer;

    localparam int W  = 32;
    localparam int E  = 4;
    localparam int M  = 16;
    localparam int BW = W * E;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   count;
        logic         last;
    } flit_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          v_i = 1'b0;
    logic          w_i = 1'b0;
    logic [3:0]    addr_i = '0;
    logic [BW-1:0] data_i = '0;
    logic [15:0]   w_mask_i = '0;
    logic          ready_and_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          last_o;
    logic [1:0]    count_o;
    logic          ready_and_i = 1'b1;

    int checks = 0;
    int errors = 0;
    flit_t exp_q[$];
    logic [BW-1:0] model_mem [M];

    always #5 clk = ~clk;

    blk_mem_serializer #(.width_p(W), .els_p(E), .mem_els_p(M)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .v_i         (v_i),
        .w_i         (w_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .w_mask_i    (w_mask_i),
        .ready_and_o (ready_and_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .last_o      (last_o),
        .count_o     (count_o),
        .ready_and_i (ready_and_i)
    );

    // Scoreboard consumer: every accepted flit must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && v_o && ready_and_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL flit_unexpected data=%h count=%0d", data_o, count_o);
            end else begin
                flit_t e;
                e = exp_q.pop_front();
                if (data_o !== e.data || count_o !== e.count || last_o !== e.last
                    || ready_and_o !== e.last) begin
                    errors++;
                    $display("FAIL flit got data=%h count=%0d last=%b rdy=%b want data=%h count=%0d last=%b rdy=%b",
                             data_o, count_o, last_o, ready_and_o, e.data, e.count, e.last, e.last);
                end
            end
        end
    end

    task automatic push_block(input logic [3:0] a);
        for (int i = 0; i < E; i++) begin
            flit_t f;
            f.data  = model_mem[a][W*i +: W];
            f.count = 2'(i);
            f.last  = (i == E - 1);
            exp_q.push_back(f);
        end
    endtask

    // Called right after a posedge; returns right after the posedge that
    // completes the write.
    task automatic do_write(input logic [3:0] a, input logic [BW-1:0] d, input logic [15:0] m);
        v_i = 1'b1; w_i = 1'b1; addr_i = a; data_i = d; w_mask_i = m;
        @(posedge clk); #1;
        v_i = 1'b0; w_i = 1'b0;
        for (int b = 0; b < BW/8; b++)
            if (m[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic issue_read(input logic [3:0] a);
        v_i = 1'b1; w_i = 1'b0; addr_i = a;
        push_block(a);
        @(posedge clk); #1;
        v_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain_timeout remaining=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (v_o !== 1'b0 || last_o !== 1'b0 || count_o !== 2'd0 || ready_and_o !== 1'b1 || data_o !== '0) begin
            errors++;
            $display("FAIL reset got v=%b last=%b count=%0d rdy=%b data=%h want 0 0 0 1 0",
                     v_o, last_o, count_o, ready_and_o, data_o);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_full_write_read();
        do_write(4'd3, 128'h44444444_33333333_22222222_11111111, 16'hFFFF);
        issue_read(4'd3);
        @(negedge clk);
        checks++;
        if (v_o !== 1'b1 || count_o !== 2'd0) begin
            errors++;
            $display("FAIL read_latency got v=%b count=%0d want 1 0", v_o, count_o);
        end
        // Four flits on four consecutive cycles: done by the 4th edge.
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL full_throughput got remaining=%0d v=%b want 0 0", exp_q.size(), v_o);
        end
        wait_drain("full");
    endtask

    task automatic test_partial_mask();
        do_write(4'd5, {BW{1'b1}}, 16'hFFFF);
        do_write(4'd5, {E{32'hA5A5A5A5}}, 16'h00F0);
        checks++;
        if (model_mem[5] !== 128'hFFFFFFFF_FFFFFFFF_A5A5A5A5_FFFFFFFF) begin
            errors++;
            $display("FAIL mask_model got %h want FFFFFFFF_FFFFFFFF_A5A5A5A5_FFFFFFFF", model_mem[5]);
        end
        issue_read(4'd5);
        wait_drain("partial");
    endtask

    task automatic test_backpressure();
        issue_read(4'd3);          // flit 0 presented
        @(posedge clk); #1;        // flit 0 accepted, now count 1
        ready_and_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (v_o !== 1'b1 || count_o !== 2'd1 || data_o !== model_mem[3][W +: W]) begin
                errors++;
                $display("FAIL backpressure cyc=%0d got v=%b count=%0d data=%h want 1 1 %h",
                         i, v_o, count_o, data_o, model_mem[3][W +: W]);
            end
        end
        @(posedge clk); #1;
        ready_and_i = 1'b1;
        wait_drain("backpressure");
    endtask

    task automatic test_unwritten();
        for (int i = 0; i < E; i++) begin
            flit_t f;
            f.data = 32'h0; f.count = 2'(i); f.last = (i == E - 1);
            exp_q.push_back(f);
        end
        v_i = 1'b1; w_i = 1'b0; addr_i = 4'd9;
        @(posedge clk); #1;
        v_i = 1'b0;
        wait_drain("unwritten");
    endtask

    task automatic test_back_to_back();
        issue_read(4'd5);          // flit 0 of addr 5
        repeat (3) @(posedge clk);
        #1;                        // flit 3 of addr 5 presented
        checks++;
        if (last_o !== 1'b1 || ready_and_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last got last=%b rdy=%b want 1 1", last_o, ready_and_o);
        end
        v_i = 1'b1; w_i = 1'b0; addr_i = 4'd3;
        push_block(4'd3);
        @(posedge clk); #1;
        v_i = 1'b0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b1 || count_o !== 2'd0 || data_o !== 32'h11111111) begin
            errors++;
            $display("FAIL b2b_no_bubble got v=%b count=%0d data=%h want 1 0 11111111", v_o, count_o, data_o);
        end
        wait_drain("b2b");
    endtask

    task automatic test_reset_mid_send();
        issue_read(4'd5);
        repeat (2) @(posedge clk);
        #1;                        // count 2
        checks++;
        if (count_o !== 2'd2) begin
            errors++;
            $display("FAIL midreset_pre got count=%0d want 2", count_o);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (v_o !== 1'b0 || count_o !== 2'd0 || ready_and_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async got v=%b count=%0d rdy=%b want 0 0 1", v_o, count_o, ready_and_o);
        end
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        issue_read(4'd3);
        wait_drain("after_reset");
    endtask

    initial begin
        for (int i = 0; i < M; i++) model_mem[i] = '0;
        test_reset();
        test_full_write_read();
        test_partial_mask();
        test_backpressure();
        test_unwritten();
        test_back_to_back();
        test_reset_mid_send();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
